// File: rtl/debug_regfile_dumper_pkg.sv
// Shared definitions for the debug register-file dumper: FSM encoding,
// default geometry and the width helper used to size address/counter fields.
package debug_regfile_dumper_pkg;

   localparam int DEF_CANT_REGISTROS      = 32;
   localparam int DEF_CANT_BITS_REGISTROS = 32;
   localparam int DEF_CANT_BITS_DATA_UART = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SET_ADDR,
      ST_CAPTURE,
      ST_SEND_BYTE,
      ST_WAIT_TX,
      ST_DONE
   } dump_state_t;

   // Number of bits needed to hold 'value' (never less than one).
   function automatic int clogb2(input int value);
      int bits;
      bits = 0;
      for (int v = value; v > 0; v = v >> 1) bits++;
      return (bits == 0) ? 1 : bits;
   endfunction

   function automatic int bytes_per_reg(input int reg_bits, input int byte_bits);
      return reg_bits / byte_bits;
   endfunction

   localparam int BYTES_PER_REG = bytes_per_reg(DEF_CANT_BITS_REGISTROS, DEF_CANT_BITS_DATA_UART);

endpackage

// File: rtl/debug_regfile_dumper.sv
// Walks the register file's debug read port and streams each register out
// over the UART TX, most-significant byte first, while the pipeline is frozen.
module debug_regfile_dumper
   import debug_regfile_dumper_pkg::*;
#(
   parameter int CANT_REGISTROS      = DEF_CANT_REGISTROS,
   parameter int CANT_BITS_REGISTROS = DEF_CANT_BITS_REGISTROS,
   parameter int CANT_BITS_DATA_UART = DEF_CANT_BITS_DATA_UART
) (
   input  logic                                   i_clock,
   input  logic                                   i_soft_reset,
   input  logic                                   i_start_dump,
   input  logic                                   i_enable_pipeline,
   input  logic [CANT_BITS_REGISTROS-1:0]         i_reg_data_from_id,
   input  logic                                   i_tx_done,
   output logic [clogb2(CANT_REGISTROS-1)-1:0]    o_reg_read_from_debug_unit,
   output logic [CANT_BITS_DATA_UART-1:0]         o_tx_data,
   output logic                                   o_tx_start,
   output logic                                   o_busy,
   output logic                                   o_dump_done,
   output logic                                   o_aborted
);

   localparam int AW = clogb2(CANT_REGISTROS-1);
   localparam int RW = CANT_BITS_REGISTROS;
   localparam int DW = CANT_BITS_DATA_UART;
   localparam int NB = bytes_per_reg(CANT_BITS_REGISTROS, CANT_BITS_DATA_UART);
   localparam int CW = clogb2(NB);
   localparam logic [AW-1:0] LAST_REG  = AW'(CANT_REGISTROS-1);
   localparam logic [CW-1:0] LAST_BYTE = CW'(NB-1);

   dump_state_t   state;
   logic [AW-1:0] reg_idx;
   logic [CW-1:0] byte_cnt;
   logic [RW-1:0] shreg;
   logic [RW-1:0] shreg_shifted;

   assign shreg_shifted = shreg << DW;

   // o_tx_data/o_tx_start are loaded on entry to SEND_BYTE so the request is
   // visible during SEND_BYTE itself; a tx_done in that cycle is never honoured.
   always_ff @(posedge i_clock or negedge i_soft_reset) begin
      if (!i_soft_reset) begin
         state                      <= ST_IDLE;
         reg_idx                    <= '0;
         byte_cnt                   <= '0;
         shreg                      <= '0;
         o_reg_read_from_debug_unit <= '0;
         o_tx_data                  <= '0;
         o_tx_start                 <= 1'b0;
         o_busy                     <= 1'b0;
         o_dump_done                <= 1'b0;
         o_aborted                  <= 1'b0;
      end else begin
         o_tx_start  <= 1'b0;
         o_dump_done <= 1'b0;
         o_aborted   <= 1'b0;
         if (state != ST_IDLE && i_enable_pipeline) begin
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
            o_aborted <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (i_start_dump && !i_enable_pipeline) begin
                     reg_idx                    <= '0;
                     o_reg_read_from_debug_unit <= '0;
                     o_busy                     <= 1'b1;
                     state                      <= ST_SET_ADDR;
                  end
               end
               ST_SET_ADDR: begin
                  state <= ST_CAPTURE;
               end
               ST_CAPTURE: begin
                  shreg      <= i_reg_data_from_id;
                  byte_cnt   <= '0;
                  o_tx_data  <= i_reg_data_from_id[RW-1 -: DW];
                  o_tx_start <= 1'b1;
                  state      <= ST_SEND_BYTE;
               end
               ST_SEND_BYTE: begin
                  state <= ST_WAIT_TX;
               end
               ST_WAIT_TX: begin
                  if (i_tx_done) begin
                     shreg    <= shreg_shifted;
                     byte_cnt <= byte_cnt + 1'b1;
                     if (byte_cnt < LAST_BYTE) begin
                        o_tx_data  <= shreg_shifted[RW-1 -: DW];
                        o_tx_start <= 1'b1;
                        state      <= ST_SEND_BYTE;
                     end else if (reg_idx < LAST_REG) begin
                        reg_idx                    <= reg_idx + 1'b1;
                        o_reg_read_from_debug_unit <= reg_idx + 1'b1;
                        state                      <= ST_SET_ADDR;
                     end else begin
                        o_dump_done <= 1'b1;
                        state       <= ST_DONE;
                     end
                  end
               end
               ST_DONE: begin
                  o_busy <= 1'b0;
                  state  <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_debug_regfile_dumper.sv
// Bench for debug_regfile_dumper: register-file and UART responders around the
// DUT, with a byte-stream model built from the register contents.
module tb_debug_regfile_dumper;

   localparam int NREG   = 32;
   localparam int RW     = 32;
   localparam int DW     = 8;
   localparam int AW     = 5;
   localparam int NB     = RW / DW;
   localparam int NBYTES = NREG * NB;

   logic          i_clock = 1'b0;
   logic          i_soft_reset = 1'b0;
   logic          i_start_dump = 1'b0;
   logic          i_enable_pipeline = 1'b0;
   logic [RW-1:0] i_reg_data_from_id;
   logic          i_tx_done;
   logic [AW-1:0] o_reg_read_from_debug_unit;
   logic [DW-1:0] o_tx_data;
   logic          o_tx_start;
   logic          o_busy;
   logic          o_dump_done;
   logic          o_aborted;

   debug_regfile_dumper dut (
      .i_clock                    (i_clock),
      .i_soft_reset               (i_soft_reset),
      .i_start_dump               (i_start_dump),
      .i_enable_pipeline          (i_enable_pipeline),
      .i_reg_data_from_id         (i_reg_data_from_id),
      .i_tx_done                  (i_tx_done),
      .o_reg_read_from_debug_unit (o_reg_read_from_debug_unit),
      .o_tx_data                  (o_tx_data),
      .o_tx_start                 (o_tx_start),
      .o_busy                     (o_busy),
      .o_dump_done                (o_dump_done),
      .o_aborted                  (o_aborted)
   );

   // ---------------- clock / reset ----------------
   always #5 i_clock = ~i_clock;

   int cyc = 0;
   always @(posedge i_clock) cyc++;

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- register file model ----------------
   logic [RW-1:0] regs [NREG];
   assign i_reg_data_from_id = regs[o_reg_read_from_debug_unit];

   // ---------------- scoreboard ----------------
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] exp_addr_q[$];
   logic [DW-1:0] log_q[$];
   int n_pass = 0;
   int n_total = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   int abort_cnt = 0;
   int first_start_cyc = -1;
   int done_cyc = -1;
   int start_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
   endtask

   // Whole-dump expectation: every register, MSB byte first, in address order.
   task automatic load_expected();
      for (int n = 0; n < NREG; n++) begin
         for (int b = 0; b < NB; b++) begin
            exp_q.push_back(regs[n][RW-1-DW*b -: DW]);
            exp_addr_q.push_back(AW'(n));
         end
      end
   endtask

   task automatic clear_expected();
      exp_q.delete();
      exp_addr_q.delete();
   endtask

   always @(negedge i_clock) begin
      if (i_soft_reset) begin
         if (o_tx_start) begin
            start_cnt++;
            log_q.push_back(o_tx_data);
            if (first_start_cyc < 0) first_start_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL tx_start_unexpected: actual=byte 0x%0h required=no transmission", o_tx_data);
            end else begin
               check("tx_byte", o_tx_data, exp_q.pop_front());
               check("tx_addr", o_reg_read_from_debug_unit, exp_addr_q.pop_front());
            end
            check("busy_during_tx", o_busy, 1'b1);
         end
         if (o_dump_done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_after_last_byte", exp_q.size(), 0);
            check("busy_during_done", o_busy, 1'b1);
         end
         if (o_aborted) abort_cnt++;
      end
   end

   // ---------------- UART responder ----------------
   int fixed_delay = 2;
   bit inject_same = 1'b0;
   bit inject_setaddr = 1'b0;
   int resp_n = 0;

   initial begin
      i_tx_done = 1'b0;
      forever begin
         @(negedge i_clock);
         if (o_tx_start && i_soft_reset) begin
            int d;
            d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 3));
            resp_n++;
            if (inject_same) i_tx_done = 1'b1;
            @(posedge i_clock); #1;
            i_tx_done = 1'b0;
            repeat (d - 1) begin
               @(posedge i_clock); #1;
            end
            i_tx_done = 1'b1;
            @(posedge i_clock); #1;
            i_tx_done = 1'b0;
            // Last byte of a register: the next cycle is SET_ADDR.
            if (inject_setaddr && (resp_n % NB) == 0) begin
               i_tx_done = 1'b1;
               @(posedge i_clock); #1;
               i_tx_done = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      @(negedge i_clock);
      i_start_dump = 1'b1;
      @(posedge i_clock); #1;
      start_cyc = cyc;
      i_start_dump = 1'b0;
   endtask

   task automatic begin_dump();
      log_q.delete();
      start_cnt = 0;
      done_cnt = 0;
      first_start_cyc = -1;
      done_cyc = -1;
      resp_n = 0;
      load_expected();
      pulse_start();
   endtask

   task automatic wait_done(input int limit);
      int base;
      base = done_cnt;
      for (int i = 0; i < limit && done_cnt == base; i++) @(posedge i_clock);
      if (done_cnt == base) check("done_timeout", 1'b0, 1'b1);
      repeat (3) @(posedge i_clock);
      #1;
   endtask

   task automatic wait_starts(input int target, input int limit);
      for (int i = 0; i < limit && start_cnt < target; i++) begin
         @(posedge i_clock); #1;
      end
      check("reach_byte", start_cnt, target);
   endtask

   task automatic preload_pattern();
      for (int n = 0; n < NREG; n++) regs[n] = 32'h0102_0300 + n;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_addr"},  o_reg_read_from_debug_unit, '0);
      check({tag, "_data"},  o_tx_data, '0);
      check({tag, "_start"}, o_tx_start, 1'b0);
      check({tag, "_busy"},  o_busy, 1'b0);
      check({tag, "_done"},  o_dump_done, 1'b0);
      check({tag, "_abort"}, o_aborted, 1'b0);
   endtask

   task automatic check_full_dump(input string tag, input bit exact_timing);
      check({tag, "_bytes"}, start_cnt, NBYTES);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_left"}, exp_q.size(), 0);
      check({tag, "_first_byte"}, log_q[0], 8'h01);
      check({tag, "_byte3"}, log_q[3], 8'h00);
      check({tag, "_byte126"}, log_q[126], 8'h03);
      check({tag, "_last_byte"}, log_q[127], 8'h1F);
      check({tag, "_last_addr"}, o_reg_read_from_debug_unit, 5'd31);
      check({tag, "_busy_after"}, o_busy, 1'b0);
      if (exact_timing) begin
         // Start edge k: first request after edge k+2; 32 regs x (2 + 4x3) cycles.
         check({tag, "_first_lat"}, first_start_cyc - start_cyc, 2);
         check({tag, "_done_lat"}, done_cyc - start_cyc, NREG * (2 + NB * 3));
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      for (int n = 0; n < NREG; n++) regs[n] = '0;
      repeat (3) @(posedge i_clock);
      #1;
      check_idle_outputs("in_reset");
      @(negedge i_clock);
      i_soft_reset = 1'b1;
      @(posedge i_clock); #1;
      check_idle_outputs("after_reset");

      // Start while the pipeline runs: no response at all.
      preload_pattern();
      begin
         int busy_seen;
         busy_seen = 0;
         i_enable_pipeline = 1'b1;
         pulse_start();
         for (int i = 0; i < 10; i++) begin
            @(negedge i_clock);
            if (o_busy) busy_seen++;
         end
         check("run_start_busy", busy_seen, 0);
         check("run_start_tx", start_cnt, 0);
         check("run_start_addr", o_reg_read_from_debug_unit, 5'd0);
         i_enable_pipeline = 1'b0;
      end

      // Full dump, tx_done two cycles after each request.
      fixed_delay = 2;
      begin_dump();
      wait_done(3000);
      check_full_dump("full", 1'b1);
      check("full_abort_cnt", abort_cnt, 0);

      // Stray tx_done with the request and during SET_ADDR: must be dropped.
      inject_same = 1'b1;
      inject_setaddr = 1'b1;
      begin_dump();
      wait_done(3000);
      check_full_dump("inject", 1'b1);
      inject_same = 1'b0;
      inject_setaddr = 1'b0;

      // Abort during reg 5, byte 2 (23rd byte).
      begin_dump();
      wait_starts(5 * NB + 3, 2000);
      i_enable_pipeline = 1'b1;
      @(posedge i_clock); #1;
      check("abort_pulse", o_aborted, 1'b1);
      check("abort_busy", o_busy, 1'b0);
      @(posedge i_clock); #1;
      check("abort_single", o_aborted, 1'b0);
      i_enable_pipeline = 1'b0;
      repeat (8) @(posedge i_clock);
      #1;
      check("abort_cnt", abort_cnt, 1);
      check("abort_no_done", done_cnt, 0);
      check("abort_tx_cnt", start_cnt, 5 * NB + 3);
      check("abort_last_byte", log_q[5 * NB + 2], 8'h03);
      clear_expected();
      begin_dump();
      wait_done(3000);
      check_full_dump("restart", 1'b0);
      check("restart_abort_cnt", abort_cnt, 1);

      // Random contents and UART latency, with a second start mid-dump.
      fixed_delay = 0;
      for (int r = 0; r < 2; r++) begin
         int at;
         for (int n = 0; n < NREG; n++) regs[n] = $urandom;
         begin_dump();
         at = $urandom_range(10, 100);
         wait_starts(at, 2000);
         pulse_start();
         check("restart_ignored_busy", o_busy, 1'b1);
         wait_done(5000);
         check("rand_bytes", start_cnt, NBYTES);
         check("rand_done_cnt", done_cnt, 1);
         check("rand_left", exp_q.size(), 0);
      end

      // Asynchronous reset in the middle of WAIT_TX.
      fixed_delay = 3;
      preload_pattern();
      begin
         int d0, a0;
         begin_dump();
         wait_starts(6, 2000);
         d0 = done_cnt;
         a0 = abort_cnt;
         #2;
         i_soft_reset = 1'b0;
         #1;
         check_idle_outputs("async_reset");
         repeat (2) @(posedge i_clock);
         @(negedge i_clock);
         i_soft_reset = 1'b1;
         repeat (6) @(posedge i_clock);
         #1;
         check("reset_no_done", done_cnt, d0);
         check("reset_no_abort", abort_cnt, a0);
         check("reset_idle_busy", o_busy, 1'b0);
         clear_expected();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
